// File: rtl/lfsr_checker_pkg.sv
// lfsr_checker_pkg
//   Shared definitions for the 4-bit LFSR pattern generator and its checker.
//   Holds the word width, the checker FSM encodings and the sequence law.
//   The generator and the checker both call lfsr4_next, so they always
//   agree on which word comes next.
package lfsr_checker_pkg;

  localparam int LFSR_W = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // The sequence law: shift right and feed S[1]^S[0] back into the MSB.
  // The period is 15, and the all-zero word can never occur in the sequence.
  function automatic logic [LFSR_W-1:0] lfsr4_next(input logic [LFSR_W-1:0] s);
    return {s[1] ^ s[0], s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// sat_counter
//   A W-bit up counter. It stops at all-ones, and clear takes priority over increment.
//   Ports:
//     clk  in   1  clock, rising edge
//     rst  in   1  asynchronous active-low reset
//     clr  in   1  synchronous clear; wins over inc in the same cycle
//     inc  in   1  count up by one unless already saturated
//     cnt  out  W  current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // The counter holds at all-ones so a long error burst cannot wrap back to a small value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Receive-side checker for the 4-bit LFSR word stream. It locks onto the
//   stream by itself, predicts each next word, and flags and counts
//   mispredictions while locked.
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      asynchronous active-low reset
//     clr        in   1      synchronous clear of err_cnt and zero_det
//     in_valid   in   1      in_data carries a generator word this cycle
//     in_data    in   4      received word
//     locked     out  1      checker synchronised to the stream
//     err_pulse  out  1      previous accepted word mismatched while locked
//     err_cnt    out  ERR_W  saturating count of locked mismatches
//     zero_det   out  1      sticky: an all-zero (illegal) word was seen
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              zero_det
);

  localparam int MAX_CNT = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  // These hold the last counter value before a transition. When cnt equals
  // one of them and the current word matches (or misses), this word is the
  // LOCK_CNT-th match (or the LOSS_CNT-th miss).
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_CNT - 1);

  state_t            state;
  logic [LFSR_W-1:0] pred;
  logic [CNT_W-1:0]  cnt;

  logic data_zero;
  logic data_match;
  logic lock_miss;

  // A word that is accepted while locked and differs from the prediction is an
  // error. An all-zero word counts as an error too.
  assign data_zero  = (in_data == '0);
  assign data_match = (in_data == pred);
  assign lock_miss  = in_valid && (state == LOCKED) && !data_match;

  // Main FSM. In HUNT and SYNC the prediction is re-seeded from the received
  // data. Once LOCKED, the prediction runs freely from its own value, so a
  // corrupted word cannot throw the checker out of step. Only a run of
  // LOSS_CNT consecutive misses sends it back to HUNT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      pred      <= '0;
      cnt       <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      zero_det  <= 1'b0;
    end else begin
      err_pulse <= lock_miss;

      if (clr) begin
        zero_det <= 1'b0;
      end else if (in_valid && data_zero) begin
        zero_det <= 1'b1;
      end

      if (in_valid) begin
        case (state)
          HUNT: begin
            if (!data_zero) begin
              pred  <= lfsr4_next(in_data);
              cnt   <= '0;
              state <= SYNC;
            end
          end
          SYNC: begin
            if (data_zero) begin
              cnt   <= '0;
              state <= HUNT;
            end else if (data_match) begin
              pred <= lfsr4_next(in_data);
              if (cnt == LOCK_LAST) begin
                cnt    <= '0;
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              pred <= lfsr4_next(in_data);
              cnt  <= '0;
            end
          end
          LOCKED: begin
            pred <= lfsr4_next(pred);
            if (data_match) begin
              cnt <= '0;
            end else if (cnt == LOSS_LAST) begin
              cnt    <= '0;
              state  <= HUNT;
              locked <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            cnt    <= '0;
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // A clear in the same cycle as an error wins. err_pulse still reports that error.
  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (lock_miss),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
//   Scoreboard bench for lfsr_checker. A behavioural model runs the sequence
//   law and the HUNT/SYNC/LOCKED rules. Each driven word pushes the model's
//   expected outputs to a queue. The expected outputs are popped and compared
//   one clock later. A second instance (ERR_W=2, LOSS_CNT=8) covers saturation
//   and the clear-versus-error priority.
module tb_lfsr_checker;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       inValid;
  logic [3:0] inData;
  logic       locked;
  logic       errPulse;
  logic [7:0] errCnt;
  logic       zeroDet;

  logic       clr5;
  logic       valid5;
  logic [3:0] data5;
  logic       locked5;
  logic       pulse5;
  logic [1:0] errCnt5;
  logic       zero5;

  int checks;
  int failures;

  typedef struct packed {
    logic       locked;
    logic       errPulse;
    logic [7:0] errCnt;
    logic       zeroDet;
  } expect_t;

  expect_t sbQueue[$];

  // The reference model state, kept in the bench's own variables.
  int         mState;
  logic [3:0] mPred;
  int         mCnt;
  int         mErr;
  logic       mZero;
  logic       mPulse;

  lfsr_checker dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (inValid),
    .in_data   (inData),
    .locked    (locked),
    .err_pulse (errPulse),
    .err_cnt   (errCnt),
    .zero_det  (zeroDet)
  );

  lfsr_checker #(
    .LOCK_CNT (3),
    .LOSS_CNT (8),
    .ERR_W    (2)
  ) dut5 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr5),
    .in_valid  (valid5),
    .in_data   (data5),
    .locked    (locked5),
    .err_pulse (pulse5),
    .err_cnt   (errCnt5),
    .zero_det  (zero5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] nxt(input logic [3:0] s);
    return {s[1] ^ s[0], s[3:1]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mState = 0;
    mPred  = 4'd0;
    mCnt   = 0;
    mErr   = 0;
    mZero  = 1'b0;
    mPulse = 1'b0;
    sbQueue.delete();
  endtask

  task automatic modelStep(input logic v, input logic [3:0] d, input logic c);
    logic errInc;
    errInc = 1'b0;
    if (v) begin
      if (d == 4'd0) mZero = 1'b1;
      case (mState)
        0: begin
          if (d != 4'd0) begin
            mPred  = nxt(d);
            mCnt   = 0;
            mState = 1;
          end
        end
        1: begin
          if (d == 4'd0) begin
            mState = 0;
            mCnt   = 0;
          end else if (d == mPred) begin
            mCnt  = mCnt + 1;
            mPred = nxt(d);
            if (mCnt == 3) begin
              mState = 2;
              mCnt   = 0;
            end
          end else begin
            mPred = nxt(d);
            mCnt  = 0;
          end
        end
        default: begin
          if (d == mPred) begin
            mCnt = 0;
          end else begin
            errInc = 1'b1;
            mCnt   = mCnt + 1;
            if (mCnt == 3) begin
              mState = 0;
              mCnt   = 0;
            end
          end
          mPred = nxt(mPred);
        end
      endcase
    end
    mPulse = errInc;
    if (errInc && mErr < 255) mErr = mErr + 1;
    if (c) begin
      mErr  = 0;
      mZero = 1'b0;
    end
  endtask

  // Drive one cycle on the main instance, push the model's prediction, then
  // compare it with the registered outputs just after the edge.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic c);
    expect_t e;
    expect_t got;
    inValid = v;
    inData  = d;
    clr     = c;
    modelStep(v, d, c);
    e.locked   = (mState == 2);
    e.errPulse = mPulse;
    e.errCnt   = 8'(mErr);
    e.zeroDet  = mZero;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    if (sbQueue.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL sb_empty observed=0 expected=1");
    end else begin
      got = sbQueue.pop_front();
      checkOutput("sb_locked", 32'(locked), 32'(got.locked));
      checkOutput("sb_err_pulse", 32'(errPulse), 32'(got.errPulse));
      checkOutput("sb_err_cnt", 32'(errCnt), 32'(got.errCnt));
      checkOutput("sb_zero_det", 32'(zeroDet), 32'(got.zeroDet));
    end
    inValid = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic drive5(input logic v, input logic [3:0] d, input logic c);
    valid5 = v;
    data5  = d;
    clr5   = c;
    @(posedge clk);
    #1;
    valid5 = 1'b0;
    clr5   = 1'b0;
  endtask

  task automatic resetAll();
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic sendLegal(input logic [3:0] start, input int n);
    logic [3:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, p, 1'b0);
      p = nxt(p);
    end
  endtask

  initial begin
    logic [3:0] p;
    int         sent;
    int         nErr;
    checks   = 0;
    failures = 0;
    clr      = 1'b0;
    inValid  = 1'b0;
    inData   = 4'd0;
    clr5     = 1'b0;
    valid5   = 1'b0;
    data5    = 4'd0;
    modelReset();

    // The reset falling edge comes before any clock edge, so the outputs must clear without a clock.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #2;
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_err_pulse", 32'(errPulse), 32'd0);
    checkOutput("rst_err_cnt", 32'(errCnt), 32'd0);
    checkOutput("rst_zero_det", 32'(zeroDet), 32'd0);
    checkOutput("rst_err_cnt5", 32'(errCnt5), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // T1: lock on a clean stream
    applyStimulus(1'b1, 4'b1000, 1'b0);
    applyStimulus(1'b1, 4'b0100, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    checkOutput("t1_not_yet_locked", 32'(locked), 32'd0);
    applyStimulus(1'b1, 4'b1001, 1'b0);
    checkOutput("t1_locked", 32'(locked), 32'd1);
    checkOutput("t1_err_cnt", 32'(errCnt), 32'd0);

    // T2: single corrupted word, flywheel keeps the lock
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("t2_err_pulse", 32'(errPulse), 32'd1);
    checkOutput("t2_err_cnt", 32'(errCnt), 32'd1);
    checkOutput("t2_locked", 32'(locked), 32'd1);
    applyStimulus(1'b1, 4'b0110, 1'b0);
    checkOutput("t2_pulse_gone", 32'(errPulse), 32'd0);
    applyStimulus(1'b1, 4'b1011, 1'b0);
    checkOutput("t2_err_cnt_hold", 32'(errCnt), 32'd1);

    // T3: clear with no valid word, then three misses lose the lock
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("t3_clr_locked", 32'(locked), 32'd1);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    checkOutput("t3_still_locked", 32'(locked), 32'd1);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    checkOutput("t3_err_cnt", 32'(errCnt), 32'd3);
    checkOutput("t3_unlocked", 32'(locked), 32'd0);
    checkOutput("t3_last_pulse", 32'(errPulse), 32'd1);
    sendLegal(4'b0001, 4);
    checkOutput("t3_relocked", 32'(locked), 32'd1);

    // T4: legal stream with random gaps; garbage on invalid cycles is ignored
    resetAll();
    p    = 4'b0011;
    sent = 0;
    for (int i = 0; i < 200 && sent < 20; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(1'b1, p, 1'b0);
        p = nxt(p);
        sent++;
      end else begin
        applyStimulus(1'b0, 4'($urandom), 1'b0);
      end
    end
    checkOutput("t4_sent", 32'(sent), 32'd20);
    checkOutput("t4_locked", 32'(locked), 32'd1);
    checkOutput("t4_err_cnt", 32'(errCnt), 32'd0);

    // T5: 2-bit counter saturates at 3; clear beats a same-cycle error
    p = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      drive5(1'b1, p, 1'b0);
      p = nxt(p);
    end
    checkOutput("t5_locked", 32'(locked5), 32'd1);
    nErr = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        drive5(1'b1, p ^ 4'hF, 1'b0);
        nErr++;
        checkOutput("t5_pulse", 32'(pulse5), 32'd1);
        checkOutput("t5_err_cnt", 32'(errCnt5), (nErr < 3) ? 32'(nErr) : 32'd3);
      end else begin
        drive5(1'b1, p, 1'b0);
        checkOutput("t5_no_pulse", 32'(pulse5), 32'd0);
      end
      p = nxt(p);
    end
    checkOutput("t5_still_locked", 32'(locked5), 32'd1);
    drive5(1'b1, p ^ 4'hF, 1'b1);
    checkOutput("t5_clr_err_cnt", 32'(errCnt5), 32'd0);
    checkOutput("t5_clr_pulse", 32'(pulse5), 32'd1);

    // T6: zero word in HUNT, then asynchronous reset while locked
    resetAll();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t6_zero_det", 32'(zeroDet), 32'd1);
    checkOutput("t6_hunt_locked", 32'(locked), 32'd0);
    sendLegal(4'b1000, 4);
    checkOutput("t6_locked", 32'(locked), 32'd1);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("t6_err_cnt", 32'(errCnt), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_async_locked", 32'(locked), 32'd0);
    checkOutput("t6_async_err_pulse", 32'(errPulse), 32'd0);
    checkOutput("t6_async_err_cnt", 32'(errCnt), 32'd0);
    checkOutput("t6_async_zero_det", 32'(zeroDet), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
